// File: rtl/cdb_reservation_station_pkg.sv
// Shared types and default sizing for the CDB reservation station.
package cdb_reservation_station_pkg;

  localparam int DEF_BW_PROCESSOR_DATA = 32;
  localparam int DEF_BW_TAG            = 4;
  localparam int DEF_BW_OP             = 4;
  localparam int DEF_NUM_ENTRY         = 4;
  localparam int DEF_TAG_BASE          = 1;

  typedef struct packed {
    logic                             pending;
    logic [DEF_BW_TAG-1:0]            tag;
    logic [DEF_BW_PROCESSOR_DATA-1:0] data;
  } operand_t;

  typedef struct packed {
    logic                 busy;
    logic [DEF_BW_OP-1:0] op;
    operand_t             rs1;
    operand_t             rs2;
  } entry_t;

endpackage

// File: rtl/cdb_rs_operand.sv
// One operand slot: holds value or producer tag and captures the value off the CDB.
module cdb_rs_operand
  import cdb_reservation_station_pkg::*;
#(
  parameter int BW_PROCESSOR_DATA = DEF_BW_PROCESSOR_DATA,
  parameter int BW_TAG            = DEF_BW_TAG
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         snoop_en,
  input  operand_t                     load_val,
  input  logic                         cdb_valid,
  input  logic [BW_TAG-1:0]            cdb_tag,
  input  logic [BW_PROCESSOR_DATA-1:0] cdb_data,
  output logic                         pending,
  output logic [BW_PROCESSOR_DATA-1:0] data
);

  logic              slot_pending;
  logic [BW_TAG-1:0] slot_tag;
  logic              hit_load;
  logic              hit_snoop;

  // Load-time hit is the issue bypass: the producer broadcasts in the issue cycle.
  assign hit_load  = load_val.pending && cdb_valid && (load_val.tag == cdb_tag);
  assign hit_snoop = snoop_en && slot_pending && cdb_valid && (slot_tag == cdb_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         slot_pending <= 1'b0;
    else if (load)      slot_pending <= load_val.pending && !hit_load;
    else if (hit_snoop) slot_pending <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      slot_tag <= load_val.tag;
      data     <= hit_load ? cdb_data : load_val.data;
    end else if (hit_snoop) begin
      data <= cdb_data;
    end
  end

  assign pending = slot_pending;

endmodule

// File: rtl/find_from_lsb.sv
// Returns the index of the lowest set bit of a vector.
module FindFromLsb #(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cdb_reservation_station.sv
// Reservation station: snoops the CDB for pending operands and dispatches the oldest ready entry.
module cdb_reservation_station
  import cdb_reservation_station_pkg::*;
#(
  parameter int BW_PROCESSOR_DATA = DEF_BW_PROCESSOR_DATA,
  parameter int BW_TAG            = DEF_BW_TAG,
  parameter int BW_OP             = DEF_BW_OP,
  parameter int NUM_ENTRY         = DEF_NUM_ENTRY,
  parameter int TAG_BASE          = DEF_TAG_BASE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_issue_valid,
  output logic                         i_issue_ready,
  input  logic [BW_OP-1:0]             i_issue_op,
  input  logic                         i_issue_rs1_pending,
  input  logic [BW_TAG-1:0]            i_issue_rs1_tag,
  input  logic [BW_PROCESSOR_DATA-1:0] i_issue_rs1_data,
  input  logic                         i_issue_rs2_pending,
  input  logic [BW_TAG-1:0]            i_issue_rs2_tag,
  input  logic [BW_PROCESSOR_DATA-1:0] i_issue_rs2_data,
  output logic [BW_TAG-1:0]            o_alloc_tag,
  input  logic                         i_cdb_valid,
  input  logic [BW_TAG-1:0]            i_cdb_tag,
  input  logic [BW_PROCESSOR_DATA-1:0] i_cdb_data,
  output logic                         o_exe_valid,
  input  logic                         o_exe_ready,
  output logic [BW_OP-1:0]             o_exe_op,
  output logic [BW_TAG-1:0]            o_exe_tag,
  output logic [BW_PROCESSOR_DATA-1:0] o_exe_rs1_data,
  output logic [BW_PROCESSOR_DATA-1:0] o_exe_rs2_data
);

  localparam int IDX_W = $clog2(NUM_ENTRY);

  logic [NUM_ENTRY-1:0]         busy;
  logic [BW_OP-1:0]             op_q [NUM_ENTRY];
  logic [IDX_W-1:0]             age [NUM_ENTRY];
  logic [NUM_ENTRY-1:0]         rs1_pending, rs2_pending, rdy;
  logic [BW_PROCESSOR_DATA-1:0] rs1_data [NUM_ENTRY];
  logic [BW_PROCESSOR_DATA-1:0] rs2_data [NUM_ENTRY];
  logic                         lock;
  logic [IDX_W-1:0]             lock_idx;
  logic                         free_found, sel_found;
  logic [IDX_W-1:0]             alloc_idx, sel_idx, sel_age, exe_idx;
  logic                         issue_fire, exe_fire;
  operand_t                     issue_rs1, issue_rs2;

  FindFromLsb #(.WIDTH(NUM_ENTRY), .IDX_W(IDX_W)) u_find_free (
    .vec   (~busy),
    .found (free_found),
    .index (alloc_idx)
  );

  assign i_issue_ready = free_found && !i_flush;
  assign o_alloc_tag   = BW_TAG'(TAG_BASE) + BW_TAG'(alloc_idx);
  assign issue_fire    = i_issue_valid && i_issue_ready;
  assign issue_rs1     = '{pending: i_issue_rs1_pending, tag: i_issue_rs1_tag, data: i_issue_rs1_data};
  assign issue_rs2     = '{pending: i_issue_rs2_pending, tag: i_issue_rs2_tag, data: i_issue_rs2_data};

  for (genvar i = 0; i < NUM_ENTRY; i++) begin : g_entry
    logic load;
    assign load = issue_fire && (alloc_idx == IDX_W'(i));

    cdb_rs_operand #(.BW_PROCESSOR_DATA(BW_PROCESSOR_DATA), .BW_TAG(BW_TAG)) u_rs1 (
      .clk, .rst_n, .load, .snoop_en(busy[i] && !i_flush), .load_val(issue_rs1),
      .cdb_valid(i_cdb_valid), .cdb_tag(i_cdb_tag), .cdb_data(i_cdb_data),
      .pending(rs1_pending[i]), .data(rs1_data[i])
    );
    cdb_rs_operand #(.BW_PROCESSOR_DATA(BW_PROCESSOR_DATA), .BW_TAG(BW_TAG)) u_rs2 (
      .clk, .rst_n, .load, .snoop_en(busy[i] && !i_flush), .load_val(issue_rs2),
      .cdb_valid(i_cdb_valid), .cdb_tag(i_cdb_tag), .cdb_data(i_cdb_data),
      .pending(rs2_pending[i]), .data(rs2_data[i])
    );
  end

  assign rdy = busy & ~rs1_pending & ~rs2_pending;

  // Ages are unique among busy entries, so the largest age is the oldest ready one.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (rdy[i] && (!sel_found || age[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age[i];
      end
    end
  end

  assign exe_idx     = lock ? lock_idx : sel_idx;
  assign o_exe_valid = (lock || sel_found) && !i_flush;
  assign exe_fire    = o_exe_valid && o_exe_ready;

  always_comb begin
    o_exe_op       = '0;
    o_exe_tag      = '0;
    o_exe_rs1_data = '0;
    o_exe_rs2_data = '0;
    if (o_exe_valid) begin
      o_exe_op       = op_q[exe_idx];
      o_exe_tag      = BW_TAG'(TAG_BASE) + BW_TAG'(exe_idx);
      o_exe_rs1_data = rs1_data[exe_idx];
      o_exe_rs2_data = rs2_data[exe_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) age[i] <= '0;
    end else if (i_flush) begin
      busy <= '0;
      lock <= 1'b0;
      for (int i = 0; i < NUM_ENTRY; i++) age[i] <= '0;
    end else begin
      lock     <= o_exe_valid && !o_exe_ready;
      lock_idx <= exe_idx;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        if (exe_fire && exe_idx == IDX_W'(i)) busy[i] <= 1'b0;
        // An issue target is always free, so it never collides with the dispatched entry.
        if (issue_fire && alloc_idx == IDX_W'(i)) begin
          busy[i] <= 1'b1;
          age[i]  <= '0;
        end else if (busy[i]) begin
          age[i] <= age[i] + IDX_W'(issue_fire) - IDX_W'(exe_fire && (age[i] > age[exe_idx]));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue_fire) op_q[alloc_idx] <= i_issue_op;
  end

endmodule

// File: tb/tb_cdb_reservation_station.sv
// Directed scenarios plus randomized traffic checked against an issue-order queue model.
module tb_cdb_reservation_station;

  localparam int N  = 4;
  localparam int TB = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_issue_valid = 1'b0;
  logic        i_issue_ready;
  logic [3:0]  i_issue_op = '0;
  logic        i_issue_rs1_pending = 1'b0, i_issue_rs2_pending = 1'b0;
  logic [3:0]  i_issue_rs1_tag = '0, i_issue_rs2_tag = '0;
  logic [31:0] i_issue_rs1_data = '0, i_issue_rs2_data = '0;
  logic [3:0]  o_alloc_tag;
  logic        i_cdb_valid = 1'b0;
  logic [3:0]  i_cdb_tag = '0;
  logic [31:0] i_cdb_data = '0;
  logic        o_exe_valid;
  logic        o_exe_ready = 1'b0;
  logic [3:0]  o_exe_op, o_exe_tag;
  logic [31:0] o_exe_rs1_data, o_exe_rs2_data;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cdb_reservation_station dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_issue_valid(i_issue_valid), .i_issue_ready(i_issue_ready), .i_issue_op(i_issue_op),
    .i_issue_rs1_pending(i_issue_rs1_pending), .i_issue_rs1_tag(i_issue_rs1_tag),
    .i_issue_rs1_data(i_issue_rs1_data),
    .i_issue_rs2_pending(i_issue_rs2_pending), .i_issue_rs2_tag(i_issue_rs2_tag),
    .i_issue_rs2_data(i_issue_rs2_data),
    .o_alloc_tag(o_alloc_tag),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .o_exe_valid(o_exe_valid), .o_exe_ready(o_exe_ready), .o_exe_op(o_exe_op),
    .o_exe_tag(o_exe_tag), .o_exe_rs1_data(o_exe_rs1_data), .o_exe_rs2_data(o_exe_rs2_data)
  );

  task automatic idle();
    i_flush = 1'b0; i_issue_valid = 1'b0; i_issue_op = '0;
    i_issue_rs1_pending = 1'b0; i_issue_rs1_tag = '0; i_issue_rs1_data = '0;
    i_issue_rs2_pending = 1'b0; i_issue_rs2_tag = '0; i_issue_rs2_data = '0;
    i_cdb_valid = 1'b0; i_cdb_tag = '0; i_cdb_data = '0; o_exe_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_issue(input logic [3:0] op, input logic p1, input logic [3:0] t1,
                           input logic [31:0] d1, input logic p2, input logic [3:0] t2,
                           input logic [31:0] d2);
    i_issue_valid = 1'b1; i_issue_op = op;
    i_issue_rs1_pending = p1; i_issue_rs1_tag = t1; i_issue_rs1_data = d1;
    i_issue_rs2_pending = p2; i_issue_rs2_tag = t2; i_issue_rs2_data = d2;
  endtask

  task automatic apply_reset();
    idle();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (i_issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got %0b want 1", i_issue_ready); end
    n_cmp++; if (o_alloc_tag !== 4'd1) begin n_fail++; $display("FAIL reset_alloc_tag got %0d want 1", o_alloc_tag); end
    n_cmp++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_exe_valid got %0b want 0", o_exe_valid); end
    n_cmp++; if ({o_exe_op, o_exe_tag, o_exe_rs1_data, o_exe_rs2_data} !== '0) begin n_fail++; $display("FAIL reset_exe_fields got op%0d tag%0d %0h %0h want zeros", o_exe_op, o_exe_tag, o_exe_rs1_data, o_exe_rs2_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_dispatch();
    set_issue(4'd3, 1'b0, 4'd0, 32'd10, 1'b0, 4'd0, 32'd20); #1;
    n_cmp++; if (o_alloc_tag !== 4'd1) begin n_fail++; $display("FAIL basic_alloc got %0d want 1", o_alloc_tag); end
    n_cmp++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_same_cycle got %0b want 0", o_exe_valid); end
    step(); idle(); #1;
    n_cmp++; if (o_exe_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", o_exe_valid); end
    n_cmp++; if (o_exe_tag !== 4'd1) begin n_fail++; $display("FAIL basic_tag got %0d want 1", o_exe_tag); end
    n_cmp++; if (o_exe_op !== 4'd3) begin n_fail++; $display("FAIL basic_op got %0d want 3", o_exe_op); end
    n_cmp++; if (o_exe_rs1_data !== 32'd10 || o_exe_rs2_data !== 32'd20) begin n_fail++; $display("FAIL basic_data got %0d/%0d want 10/20", o_exe_rs1_data, o_exe_rs2_data); end
    n_cmp++; if (o_alloc_tag !== 4'd2) begin n_fail++; $display("FAIL basic_alloc_next got %0d want 2", o_alloc_tag); end
    o_exe_ready = 1'b1;
    step(); o_exe_ready = 1'b0; #1;
    n_cmp++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL basic_freed_valid got %0b want 0", o_exe_valid); end
    n_cmp++; if (o_alloc_tag !== 4'd1) begin n_fail++; $display("FAIL basic_freed_alloc got %0d want 1", o_alloc_tag); end
  endtask

  task automatic test_cdb_wakeup();
    set_issue(4'd4, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd2);
    step(); idle();
    i_cdb_valid = 1'b1; i_cdb_tag = 4'd8; i_cdb_data = 32'hdead; #1;
    n_cmp++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL wake_waiting got %0b want 0", o_exe_valid); end
    step(); i_cdb_valid = 1'b1; i_cdb_tag = 4'd7; i_cdb_data = 32'h55; #1;
    n_cmp++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL wake_unrelated_or_fwd got %0b want 0", o_exe_valid); end
    step(); idle(); #1;
    n_cmp++; if (o_exe_valid !== 1'b1 || o_exe_tag !== 4'd1) begin n_fail++; $display("FAIL wake_dispatch got v%0b tag%0d want v1 tag1", o_exe_valid, o_exe_tag); end
    n_cmp++; if (o_exe_rs1_data !== 32'h55 || o_exe_rs2_data !== 32'd2) begin n_fail++; $display("FAIL wake_data got %0h/%0h want 55/2", o_exe_rs1_data, o_exe_rs2_data); end
    o_exe_ready = 1'b1; step(); o_exe_ready = 1'b0;
  endtask

  task automatic test_issue_bypass();
    set_issue(4'd5, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd3);
    i_cdb_valid = 1'b1; i_cdb_tag = 4'd5; i_cdb_data = 32'd9;
    step(); idle(); #1;
    n_cmp++; if (o_exe_valid !== 1'b1 || o_exe_rs1_data !== 32'd9) begin n_fail++; $display("FAIL bypass got v%0b rs1 %0d want v1 rs1 9", o_exe_valid, o_exe_rs1_data); end
    n_cmp++; if (o_exe_op !== 4'd5) begin n_fail++; $display("FAIL bypass_op got %0d want 5", o_exe_op); end
    o_exe_ready = 1'b1; step(); o_exe_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      set_issue(4'(k + 1), 1'b0, 4'd0, 32'(100 + k), 1'b0, 4'd0, 32'(200 + k)); #1;
      if (k > 0) begin
        n_cmp++; if (o_exe_valid !== 1'b1 || o_exe_tag !== 4'd1) begin n_fail++; $display("FAIL fill_hold_%0d got v%0b tag%0d want v1 tag1", k, o_exe_valid, o_exe_tag); end
      end
      step();
    end
    idle(); #1;
    n_cmp++; if (i_issue_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got %0b want 0", i_issue_ready); end
    o_exe_ready = 1'b1; #1;
    n_cmp++; if (i_issue_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_dispatching got %0b want 0", i_issue_ready); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (o_exe_valid !== 1'b1 || o_exe_tag !== 4'(k + 1) || o_exe_rs1_data !== 32'(100 + k)) begin n_fail++; $display("FAIL drain_%0d got v%0b tag%0d rs1 %0d want v1 tag%0d rs1 %0d", k, o_exe_valid, o_exe_tag, o_exe_rs1_data, k + 1, 100 + k); end
      step(); #1;
    end
    o_exe_ready = 1'b0; #1;
    n_cmp++; if (o_exe_valid !== 1'b0 || i_issue_ready !== 1'b1) begin n_fail++; $display("FAIL drain_empty got v%0b ir%0b want v0 ir1", o_exe_valid, i_issue_ready); end
  endtask

  task automatic test_lock();
    set_issue(4'd1, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd1); step();
    set_issue(4'd2, 1'b0, 4'd0, 32'd2, 1'b1, 4'd12, 32'd0); step();
    set_issue(4'd3, 1'b0, 4'd0, 32'd33, 1'b0, 4'd0, 32'd3); step();
    idle(); #1;
    n_cmp++; if (o_exe_valid !== 1'b1 || o_exe_tag !== 4'd3) begin n_fail++; $display("FAIL lock_first got v%0b tag%0d want v1 tag3", o_exe_valid, o_exe_tag); end
    i_cdb_valid = 1'b1; i_cdb_tag = 4'd12; i_cdb_data = 32'h77;
    step(); idle(); #1;
    n_cmp++; if (o_exe_tag !== 4'd3 || o_exe_rs1_data !== 32'd33) begin n_fail++; $display("FAIL lock_held got tag%0d rs1 %0d want tag3 rs1 33", o_exe_tag, o_exe_rs1_data); end
    step(); #1;
    n_cmp++; if (o_exe_tag !== 4'd3) begin n_fail++; $display("FAIL lock_held2 got tag%0d want 3", o_exe_tag); end
    o_exe_ready = 1'b1; step(); #1;
    n_cmp++; if (o_exe_tag !== 4'd1 || o_exe_rs1_data !== 32'h77) begin n_fail++; $display("FAIL lock_next got tag%0d rs1 %0h want tag1 rs1 77", o_exe_tag, o_exe_rs1_data); end
    step(); #1;
    n_cmp++; if (o_exe_tag !== 4'd2 || o_exe_rs2_data !== 32'h77) begin n_fail++; $display("FAIL lock_last got tag%0d rs2 %0h want tag2 rs2 77", o_exe_tag, o_exe_rs2_data); end
    step(); o_exe_ready = 1'b0; #1;
    n_cmp++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL lock_empty got %0b want 0", o_exe_valid); end
  endtask

  task automatic test_flush();
    set_issue(4'd6, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2); step();
    set_issue(4'd7, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd0); step();
    idle(); #1;
    n_cmp++; if (o_exe_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got %0b want 1", o_exe_valid); end
    i_flush = 1'b1; set_issue(4'd8, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd5); #1;
    n_cmp++; if (o_exe_valid !== 1'b0 || i_issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_comb got v%0b ir%0b want v0 ir0", o_exe_valid, i_issue_ready); end
    step(); idle(); #1;
    n_cmp++; if (o_alloc_tag !== 4'd1 || i_issue_ready !== 1'b1 || o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after got alloc%0d ir%0b v%0b want alloc1 ir1 v0", o_alloc_tag, i_issue_ready, o_exe_valid); end
    i_cdb_valid = 1'b1; i_cdb_tag = 4'd6; i_cdb_data = 32'd1;
    step(); idle(); #1;
    n_cmp++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cdb_dead got %0b want 0", o_exe_valid); end
  endtask

  task automatic test_mid_reset();
    set_issue(4'd9, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 32'd4); step(); idle(); #1;
    n_cmp++; if (o_exe_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got %0b want 1", o_exe_valid); end
    #1 rst_n = 1'b0; #1;
    n_cmp++; if (o_exe_valid !== 1'b0 || i_issue_ready !== 1'b1 || o_alloc_tag !== 4'd1) begin n_fail++; $display("FAIL midrst_async got v%0b ir%0b alloc%0d want v0 ir1 alloc1", o_exe_valid, i_issue_ready, o_alloc_tag); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_random();
    bit          m_busy [N];
    logic [3:0]  m_op [N], m_t1 [N], m_t2 [N];
    bit          m_p1 [N], m_p2 [N];
    logic [31:0] m_d1 [N], m_d2 [N];
    int          m_order [$];
    bit          m_lock;
    int          m_lock_idx;
    int          free, sel, pos;
    bit          exp_ir, exp_v;
    apply_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    m_order.delete(); m_lock = 1'b0; m_lock_idx = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      i_flush = ($urandom_range(0, 59) == 0);
      i_issue_valid = ($urandom_range(0, 9) < 6);
      i_issue_op = 4'($urandom);
      i_issue_rs1_pending = $urandom_range(0, 1); i_issue_rs1_tag = 4'($urandom_range(1, 8)); i_issue_rs1_data = $urandom;
      i_issue_rs2_pending = $urandom_range(0, 1); i_issue_rs2_tag = 4'($urandom_range(1, 8)); i_issue_rs2_data = $urandom;
      i_cdb_valid = ($urandom_range(0, 9) < 4); i_cdb_tag = 4'($urandom_range(0, 9)); i_cdb_data = $urandom;
      o_exe_ready = ($urandom_range(0, 2) != 0);
      #1;
      free = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) free = i;
      exp_ir = (free >= 0) && !i_flush;
      sel = -1;
      if (m_lock) sel = m_lock_idx;
      else foreach (m_order[j]) if (sel < 0 && !m_p1[m_order[j]] && !m_p2[m_order[j]]) sel = m_order[j];
      exp_v = (sel >= 0) && !i_flush;
      n_cmp++; if (i_issue_ready !== exp_ir) begin n_fail++; $display("FAIL rand_issue_ready cyc%0d got %0b want %0b", cyc, i_issue_ready, exp_ir); end
      if (free >= 0) begin
        n_cmp++; if (o_alloc_tag !== 4'(TB + free)) begin n_fail++; $display("FAIL rand_alloc cyc%0d got %0d want %0d", cyc, o_alloc_tag, TB + free); end
      end
      n_cmp++; if (o_exe_valid !== exp_v) begin n_fail++; $display("FAIL rand_exe_valid cyc%0d got %0b want %0b", cyc, o_exe_valid, exp_v); end
      if (exp_v) begin
        n_cmp++;
        if (o_exe_tag !== 4'(TB + sel) || o_exe_op !== m_op[sel] || o_exe_rs1_data !== m_d1[sel] || o_exe_rs2_data !== m_d2[sel]) begin
          n_fail++;
          $display("FAIL rand_exe cyc%0d got tag%0d op%0d %0h %0h want tag%0d op%0d %0h %0h", cyc, o_exe_tag, o_exe_op, o_exe_rs1_data, o_exe_rs2_data, TB + sel, m_op[sel], m_d1[sel], m_d2[sel]);
        end
      end
      @(posedge clk);
      if (i_flush) begin
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        m_order.delete(); m_lock = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m_busy[i] && i_cdb_valid && m_p1[i] && m_t1[i] == i_cdb_tag) begin m_p1[i] = 1'b0; m_d1[i] = i_cdb_data; end
          if (m_busy[i] && i_cdb_valid && m_p2[i] && m_t2[i] == i_cdb_tag) begin m_p2[i] = 1'b0; m_d2[i] = i_cdb_data; end
        end
        if (exp_v && o_exe_ready) begin
          m_busy[sel] = 1'b0;
          pos = -1;
          foreach (m_order[j]) if (m_order[j] == sel) pos = j;
          if (pos >= 0) m_order.delete(pos);
        end
        m_lock = exp_v && !o_exe_ready;
        m_lock_idx = sel;
        if (i_issue_valid && exp_ir) begin
          m_busy[free] = 1'b1; m_op[free] = i_issue_op;
          m_t1[free] = i_issue_rs1_tag; m_t2[free] = i_issue_rs2_tag;
          m_p1[free] = i_issue_rs1_pending && !(i_cdb_valid && i_cdb_tag == i_issue_rs1_tag);
          m_d1[free] = (i_issue_rs1_pending && !m_p1[free]) ? i_cdb_data : i_issue_rs1_data;
          m_p2[free] = i_issue_rs2_pending && !(i_cdb_valid && i_cdb_tag == i_issue_rs2_tag);
          m_d2[free] = (i_issue_rs2_pending && !m_p2[free]) ? i_cdb_data : i_issue_rs2_data;
          m_order.push_back(free);
        end
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_dispatch();
    test_cdb_wakeup();
    test_issue_bypass();
    test_back_to_back();
    test_lock();
    test_flush();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
